// File: rtl/img_mem_pkg.sv
// Shared definitions for the shared pixel-memory port.
//   - default widths and RAM read latency
//   - one-hot FSM state encoding (IDLE, SRV0, SRV1, GAP)
//   - owner tag encoding for in-flight reads
//   - pick_state(): state chosen from IDLE or GAP for a given grant pair
package img_mem_pkg;

    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 8;
    localparam int RD_LAT_DEF = 2;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SRV0 = 4'b0010,
        SRV1 = 4'b0100,
        GAP  = 4'b1000
    } state_t;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } owner_t;

    // A single, exclusive grant selects the master to serve; anything else idles.
    function automatic state_t pick_state(input logic gnt_0, input logic gnt_1);
        if (gnt_0 && !gnt_1) return SRV0;
        if (gnt_1 && !gnt_0) return SRV1;
        return IDLE;
    endfunction

endpackage

// File: rtl/shared_mem_port_if.sv
// Per-master command/return channel of the shared pixel-memory port.
//   cmd_valid  master -> port   command present
//   cmd_we     master -> port   1 = write, 0 = read
//   cmd_addr   master -> port   pixel address (AW bits)
//   cmd_wdata  master -> port   write pixel (DW bits)
//   cmd_ready  port -> master   command accepted when cmd_valid & cmd_ready
//   rvalid     port -> master   one-cycle read-return pulse
//   rdata      port -> master   read pixel, held between pulses
interface shared_mem_port_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_ready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready, rvalid, rdata
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready, rvalid, rdata
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line carrying {valid, owner} for every read sent to the RAM, so the
// returning data can be steered to the master that issued it regardless of
// the grant at return time.
//   clock, reset   rising-edge clock, synchronous active-high reset (clears all stages)
//   push           a read is being accepted this cycle
//   push_owner     master issuing that read
//   valid, owner   tag leaving the last stage (DEPTH cycles after push)
module rd_tag_pipe
    import img_mem_pkg::*;
#(
    parameter int DEPTH = RD_LAT_DEF + 1
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  owner_t push_owner,
    output logic   valid,
    output owner_t owner
);

    logic [DEPTH-1:0] vld;
    owner_t           own [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
            // NOTE: the owner stages are only meaningful alongside vld, but they are
            // still cleared so the pipe has one well-defined state after reset.
            for (int i = 0; i < DEPTH; i++) own[i] <= MST0;
        end else begin
            vld    <= {vld[DEPTH-2:0], push};
            own[0] <= push_owner;
            for (int i = 1; i < DEPTH; i++) own[i] <= own[i-1];
        end
    end

    assign valid = vld[DEPTH-1];
    assign owner = own[DEPTH-1];

endmodule

// File: rtl/shared_mem_port.sv
// Routes the granted master's pixel commands onto a single-port image RAM and
// returns read data to the master that issued each read.
//   clock, reset         rising-edge clock, synchronous active-high reset
//   gnt_0, gnt_1         registered grants from the arbiter
//   mst_0, mst_1         per-master command/return channels (slave side)
//   mem_en/we/addr/wdata registered RAM command
//   mem_rdata            RAM read data, valid RD_LAT cycles after a read strobe
//   acc_cnt_0/1          saturating accepted-command counters
//   grant_err            sticky flag: both grants seen high together
module shared_mem_port
    import img_mem_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 gnt_0,
    input  logic                 gnt_1,
    shared_mem_port_if.slave     mst_0,
    shared_mem_port_if.slave     mst_1,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [CNT_W-1:0]     acc_cnt_0,
    output logic [CNT_W-1:0]     acc_cnt_1,
    output logic                 grant_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t        state;
    logic          sole_0, sole_1;
    logic          accept_0, accept_1, accept;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    owner_t        sel_owner;
    logic          tag_valid;
    owner_t        tag_owner;

    assign sole_0 = gnt_0 & ~gnt_1;
    assign sole_1 = gnt_1 & ~gnt_0;

    // Ready follows the live grant so a master stops the same cycle its grant drops.
    assign mst_0.cmd_ready = (state == SRV0) & sole_0;
    assign mst_1.cmd_ready = (state == SRV1) & sole_1;

    assign accept_0 = mst_0.cmd_valid & mst_0.cmd_ready;
    assign accept_1 = mst_1.cmd_valid & mst_1.cmd_ready;
    assign accept   = accept_0 | accept_1;

    // At most one master can be accepted per cycle, so a 2:1 mux is enough.
    always_comb begin
        // NOTE: every signal is assigned before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        sel_we    = mst_0.cmd_we;
        sel_addr  = mst_0.cmd_addr;
        sel_wdata = mst_0.cmd_wdata;
        sel_owner = MST0;
        if (accept_1) begin
            sel_we    = mst_1.cmd_we;
            sel_addr  = mst_1.cmd_addr;
            sel_wdata = mst_1.cmd_wdata;
            sel_owner = MST1;
        end
    end

    // One stage per RAM latency cycle plus the registered strobe in front of it.
    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_rd_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .push       (accept & ~sel_we),
        .push_owner (sel_owner),
        .valid      (tag_valid),
        .owner      (tag_owner)
    );

    // NOTE: all state here updates with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mst_0.rvalid <= 1'b0;
            mst_0.rdata  <= '0;
            mst_1.rvalid <= 1'b0;
            mst_1.rdata  <= '0;
            acc_cnt_0    <= '0;
            acc_cnt_1    <= '0;
            grant_err    <= 1'b0;
        end else begin
            if (gnt_0 && gnt_1) begin
                state     <= IDLE;
                grant_err <= 1'b1;
            end else begin
                case (state)
                    SRV0:    state <= sole_0 ? SRV0 : GAP;
                    SRV1:    state <= sole_1 ? SRV1 : GAP;
                    default: state <= pick_state(gnt_0, gnt_1);  // IDLE and GAP
                endcase
            end

            // Address and data hold their last value on idle cycles.
            mem_en <= accept;
            mem_we <= accept & sel_we;
            if (accept) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end

            if (accept_0 && acc_cnt_0 != CNT_MAX) acc_cnt_0 <= acc_cnt_0 + 1'b1;
            if (accept_1 && acc_cnt_1 != CNT_MAX) acc_cnt_1 <= acc_cnt_1 + 1'b1;

            // Steered by the tag, not by the current grant.
            mst_0.rvalid <= tag_valid && (tag_owner == MST0);
            mst_1.rvalid <= tag_valid && (tag_owner == MST1);
            if (tag_valid && tag_owner == MST0) mst_0.rdata <= mem_rdata;
            if (tag_valid && tag_owner == MST1) mst_1.rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_shared_mem_port.sv
// Self-checking bench for shared_mem_port: a behavioural RAM with RD_LAT read
// latency, a cycle-level reference model built from the port's rules, a
// negedge compare process, directed scenarios with literal expectations, and a
// randomized traffic phase.
module tb_shared_mem_port;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int RD_LAT  = 2;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             gnt_0, gnt_1;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata, mem_rdata;
    logic [CNT_W-1:0] acc_cnt_0, acc_cnt_1;
    logic             grant_err;

    shared_mem_port_if #(.AW(AW), .DW(DW)) m0_if ();
    shared_mem_port_if #(.AW(AW), .DW(DW)) m1_if ();

    shared_mem_port #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clock     (clk),
        .reset     (reset),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .mst_0     (m0_if),
        .mst_1     (m1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .acc_cnt_0 (acc_cnt_0),
        .acc_cnt_1 (acc_cnt_1),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural RAM (environment) ----------------
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] rd_pipe [RD_LAT];

    initial for (int i = 0; i < 256; i++) ram[i] <= '0;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        // Garbage on non-read cycles: data must only be used when a tag says so.
        rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            owner;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] mdl_mem [256];
    rd_t           rd_q [$];
    int            edge_n    = 0;
    bit            m_started = 0;
    int            srv;          // -1 idle, -2 turnaround, 0/1 serving that master
    logic          e_en, e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rvalid [2];
    logic [DW-1:0] e_rdata  [2];
    int            e_cnt    [2];

    initial for (int i = 0; i < 256; i++) mdl_mem[i] = '0;

    task automatic model_step();
        bit            acc [2];
        int            m;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        edge_n++;
        m_started = 1;
        if (reset) begin
            srv = -1;
            e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_err = 0;
            for (int i = 0; i < 2; i++) begin
                e_rvalid[i] = 0; e_rdata[i] = '0; e_cnt[i] = 0;
            end
            rd_q.delete();
            return;
        end
        acc[0] = (srv == 0) && gnt_0 && !gnt_1 && m0_if.cmd_valid;
        acc[1] = (srv == 1) && gnt_1 && !gnt_0 && m1_if.cmd_valid;
        e_en = acc[0] || acc[1];
        e_we = 0;
        if (e_en) begin
            m  = acc[1] ? 1 : 0;
            we = m ? m1_if.cmd_we    : m0_if.cmd_we;
            a  = m ? m1_if.cmd_addr  : m0_if.cmd_addr;
            d  = m ? m1_if.cmd_wdata : m0_if.cmd_wdata;
            e_we = we; e_addr = a; e_wdata = d;
            if (we) mdl_mem[a[7:0]] = d;
            else    rd_q.push_back('{due: edge_n + 1 + RD_LAT, owner: m, data: mdl_mem[a[7:0]]});
            if (e_cnt[m] < CNT_MAX) e_cnt[m]++;
        end
        e_rvalid[0] = 0; e_rvalid[1] = 0;
        if (rd_q.size() > 0 && rd_q[0].due == edge_n) begin
            e_rvalid[rd_q[0].owner] = 1;
            e_rdata[rd_q[0].owner]  = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        if (gnt_0 && gnt_1) begin
            srv = -1; e_err = 1;
        end else if (srv < 0) begin
            srv = (gnt_0 && !gnt_1) ? 0 : ((gnt_1 && !gnt_0) ? 1 : -1);
        end else if (!((srv == 0 && gnt_0 && !gnt_1) || (srv == 1 && gnt_1 && !gnt_0))) begin
            srv = -2;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_started) begin
            check("cmd_ready_0", m0_if.cmd_ready, (srv == 0) && gnt_0 && !gnt_1);
            check("cmd_ready_1", m1_if.cmd_ready, (srv == 1) && gnt_1 && !gnt_0);
            check("mem_en",    mem_en,    e_en);
            check("mem_we",    mem_we,    e_we);
            check("mem_addr",  mem_addr,  e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("rvalid_0",  m0_if.rvalid, e_rvalid[0]);
            check("rvalid_1",  m1_if.rvalid, e_rvalid[1]);
            check("rdata_0",   m0_if.rdata,  e_rdata[0]);
            check("rdata_1",   m1_if.rdata,  e_rdata[1]);
            check("acc_cnt_0", acc_cnt_0, e_cnt[0]);
            check("acc_cnt_1", acc_cnt_1, e_cnt[1]);
            check("grant_err", grant_err, e_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic ready_of(input int m);
        return m ? m1_if.cmd_ready : m0_if.cmd_ready;
    endfunction

    // Presents one command and returns 2 units after the accepting edge.
    task automatic issue(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int budget = 20;
        if (m == 0) begin
            m0_if.cmd_valid = 1; m0_if.cmd_we = we; m0_if.cmd_addr = a; m0_if.cmd_wdata = d;
        end else begin
            m1_if.cmd_valid = 1; m1_if.cmd_we = we; m1_if.cmd_addr = a; m1_if.cmd_wdata = d;
        end
        #1;
        while (!ready_of(m) && budget > 0) begin
            tick();
            #1;
            budget--;
        end
        check("issue_accepted_in_budget", budget > 0, 1);
        tick();
        if (m == 0) m0_if.cmd_valid = 0;
        else        m1_if.cmd_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; gnt_0 = 1; gnt_1 = 0;
        m0_if.cmd_valid = 1; m0_if.cmd_we = 1; m0_if.cmd_addr = 16'h0010; m0_if.cmd_wdata = 8'hA0;
        m1_if.cmd_valid = 0; m1_if.cmd_we = 0; m1_if.cmd_addr = '0;       m1_if.cmd_wdata = '0;

        // 1: reset held with a valid, granted command
        for (int k = 0; k < 3; k++) begin
            tick();
            #3;
            check("reset_mem_en", mem_en, 0);
            check("reset_ready_0", m0_if.cmd_ready, 0);
            check("reset_acc_cnt_0", acc_cnt_0, 0);
        end
        reset = 0;

        // 2: M0 write burst
        for (int i = 0; i < 4; i++) issue(0, 1, 16'h0010 + 16'(i), 8'hA0 + 8'(i));
        #1;
        check("burst_acc_cnt_0", acc_cnt_0, 4);

        // 3: read latency
        issue(0, 0, 16'h0010, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            #3;
            check("lat_rvalid_0", m0_if.rvalid, k == 4);
            check("lat_rvalid_1", m1_if.rvalid, 0);
            if (k == 4) check("lat_rdata_0", m0_if.rdata, 8'hA0);
        end

        // 4: grant switch with a read in flight
        issue(0, 0, 16'h0011, 8'h00);
        gnt_0 = 0; gnt_1 = 1;
        m1_if.cmd_valid = 1; m1_if.cmd_we = 1; m1_if.cmd_addr = 16'h0020; m1_if.cmd_wdata = 8'h55;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            #3;
            check("switch_ready_1", m1_if.cmd_ready, k >= 3);
            check("switch_rvalid_0", m0_if.rvalid, k == 4);
            if (k == 4) check("switch_rdata_0", m0_if.rdata, 8'hA1);
        end
        m1_if.cmd_valid = 0;

        // 5: illegal grant pair
        tick();
        gnt_0 = 1;
        #3;
        check("illegal_ready_0", m0_if.cmd_ready, 0);
        check("illegal_ready_1", m1_if.cmd_ready, 0);
        tick();
        gnt_0 = 0;
        #3;
        check("illegal_grant_err", grant_err, 1);
        check("illegal_back_to_idle", m1_if.cmd_ready, 0);

        // 6: counter saturation
        for (int i = 0; i < 8; i++) issue(1, 1, 16'h0030 + 16'(i), 8'(i));
        #1;
        check("sat_acc_cnt_1", acc_cnt_1, CNT_MAX);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            if ($urandom_range(0, 9) == 0) begin
                int r = $urandom_range(0, 19);
                if (r == 0)      begin gnt_0 = 1; gnt_1 = 1; end
                else if (r < 4)  begin gnt_0 = 0; gnt_1 = 0; end
                else if (r < 12) begin gnt_0 = 1; gnt_1 = 0; end
                else             begin gnt_0 = 0; gnt_1 = 1; end
            end
            m0_if.cmd_valid = ($urandom_range(0, 9) < 7);
            m0_if.cmd_we    = $urandom_range(0, 1) != 0;
            m0_if.cmd_addr  = 16'h0010 + 16'($urandom_range(0, 15));
            m0_if.cmd_wdata = 8'($urandom);
            m1_if.cmd_valid = ($urandom_range(0, 9) < 7);
            m1_if.cmd_we    = $urandom_range(0, 1) != 0;
            m1_if.cmd_addr  = 16'h0010 + 16'($urandom_range(0, 15));
            m1_if.cmd_wdata = 8'($urandom);
        end
        m0_if.cmd_valid = 0; m1_if.cmd_valid = 0; gnt_0 = 0; gnt_1 = 0;
        tick();
        #1;
        check("err_still_sticky", grant_err, 1);

        // reset clears the sticky flag, then reset lands on an in-flight read
        reset = 1;
        tick();
        #1;
        check("reset_clears_err", grant_err, 0);
        reset = 0;
        gnt_0 = 1;
        issue(0, 0, 16'h0010, 8'h00);
        reset = 1;
        tick();
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            #3;
            check("flushed_rvalid_0", m0_if.rvalid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
